// File: rtl/zxuno_sram_pkg.sv
// Shared types and constants for the SRAM arbiter.
//   state_e   : access sequencer states
//   OWN_*     : bus owner codes as driven on the owner output
//   REQ_*     : bit positions of each requester in request/grant vectors
package zxuno_sram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdAck,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  localparam logic [1:0] OWN_VID  = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  localparam int unsigned REQ_VID = 0;
  localparam int unsigned REQ_CPU = 1;
  localparam int unsigned REQ_DMA = 2;

endpackage

// File: rtl/sram_arb_prio.sv
// Combinational fixed-priority picker for the SRAM arbiter.
//   req_i       : masked request vector {dma, cpu, vid}
//   dma_first_i : DMA has been skipped too often; rank it above the CPU
//   gnt_o       : one-hot grant {dma, cpu, vid}, zero when nothing requests
//   owner_o     : owner code of the winner, OWN_NONE when nothing requests
module sram_arb_prio
  import zxuno_sram_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       dma_first_i,
  output logic [2:0] gnt_o,
  output logic [1:0] owner_o
);

  always_comb begin
    gnt_o   = 3'b000;
    owner_o = OWN_NONE;
    if (req_i[REQ_VID]) begin
      gnt_o[REQ_VID] = 1'b1;
      owner_o        = OWN_VID;
    end else if (dma_first_i && req_i[REQ_DMA]) begin
      gnt_o[REQ_DMA] = 1'b1;
      owner_o        = OWN_DMA;
    end else if (req_i[REQ_CPU]) begin
      gnt_o[REQ_CPU] = 1'b1;
      owner_o        = OWN_CPU;
    end else if (req_i[REQ_DMA]) begin
      gnt_o[REQ_DMA] = 1'b1;
      owner_o        = OWN_DMA;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM port between the ULA video fetch (read-only), the Z80 CPU
// and a low-priority DMA port, sequencing fixed-timing read and write cycles.
//   clk, rst                      : system clock, synchronous active-high reset
//   vid_req/addr/ack              : video read port
//   cpu_req/we/addr/wdata/ack     : CPU read/write port
//   dma_req/we/addr/wdata/ack     : DMA read/write port
//   rdata                         : last captured read byte
//   owner                         : current bus owner (0 vid, 1 cpu, 2 dma, 3 none)
//   sram_addr/wdata/oe/rdata/we_n : SRAM pin side; the top level owns the data tristate
module sram_arbiter
  import zxuno_sram_pkg::*;
#(
  parameter int unsigned RD_CYCLES    = 2,
  parameter int unsigned WE_CYCLES    = 1,
  parameter int unsigned DMA_MAX_SKIP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_req,
  input  logic [18:0] vid_addr,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [18:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  rdata,
  output logic [1:0]  owner,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_wdata,
  output logic        sram_oe,
  input  logic [7:0]  sram_rdata,
  output logic        sram_we_n
);

  localparam int unsigned CntW  = 8;
  localparam int unsigned SkipW = $clog2(DMA_MAX_SKIP + 1);

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [18:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [SkipW-1:0]  skip_q, skip_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_n_q, we_n_d;

  logic [2:0] ack_vec;
  logic [2:0] cand;
  logic [2:0] gnt;
  logic [1:0] win_owner;
  logic       dma_first;

  // The ack of the finishing access is visible during RD_ACK / WR_HOLD; that port is masked
  // from the arbitration at the end of the same cycle.
  always_comb begin
    ack_vec = 3'b000;
    if (state_q == StRdAck || state_q == StWrHold) begin
      case (owner_q)
        OWN_VID: ack_vec[REQ_VID] = 1'b1;
        OWN_CPU: ack_vec[REQ_CPU] = 1'b1;
        OWN_DMA: ack_vec[REQ_DMA] = 1'b1;
        default: ack_vec = 3'b000;
      endcase
    end
  end

  assign cand      = {dma_req, cpu_req, vid_req} & ~ack_vec;
  assign dma_first = (skip_q == SkipW'(DMA_MAX_SKIP));

  sram_arb_prio u_prio (
    .req_i       (cand),
    .dma_first_i (dma_first),
    .gnt_o       (gnt),
    .owner_o     (win_owner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRd: begin
        if (cnt_q == '0) begin
          state_d = StRdAck;
          rdata_d = sram_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = CntW'(WE_CYCLES - 1);
      end
      StWrPulse: begin
        if (cnt_q == '0) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // StIdle, StRdAck, StWrHold: arbitration point
        owner_d = win_owner;
        cnt_d   = CntW'(RD_CYCLES - 1);
        state_d = StIdle;
        if (gnt[REQ_VID]) begin
          addr_d  = vid_addr;
          state_d = StRd;
        end else if (gnt[REQ_CPU]) begin
          addr_d  = cpu_addr;
          state_d = cpu_we ? StWrSetup : StRd;
          if (cpu_we) wdata_d = cpu_wdata;
          if (cand[REQ_DMA] && !dma_first) skip_d = skip_q + 1'b1;
        end else if (gnt[REQ_DMA]) begin
          addr_d  = dma_addr;
          state_d = dma_we ? StWrSetup : StRd;
          if (dma_we) wdata_d = dma_wdata;
          skip_d  = '0;
        end
      end
    endcase
    we_n_d = (state_d != StWrPulse);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      skip_q  <= '0;
      cnt_q   <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      we_n_q  <= we_n_d;
    end
  end

  assign vid_ack    = ack_vec[REQ_VID];
  assign cpu_ack    = ack_vec[REQ_CPU];
  assign dma_ack    = ack_vec[REQ_DMA];
  assign rdata      = rdata_q;
  assign owner      = owner_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe    = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (RD_CYCLES=2, WE_CYCLES=1, DMA_MAX_SKIP=2).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req, cpu_req, cpu_we, dma_req, dma_we;
  logic [18:0] vid_addr, cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        vid_ack, cpu_ack, dma_ack;
  logic [7:0]  rdata;
  logic [1:0]  owner;
  logic [18:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic        sram_oe;
  logic [7:0]  sram_rdata;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // SRAM model: one magic location, otherwise the low address byte.
  assign sram_rdata = (sram_addr == 19'h12345) ? 8'hA5 : sram_addr[7:0];

  sram_arbiter #(
    .RD_CYCLES    (2),
    .WE_CYCLES    (1),
    .DMA_MAX_SKIP (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .rdata      (rdata),
    .owner      (owner),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_oe    (sram_oe),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vid_req = 0; cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0;
    vid_addr = '0; cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
    step();
    step();
    checks++;
    if ({sram_we_n, sram_oe, vid_ack, cpu_ack, dma_ack, owner} !== 7'b1_0_000_11) begin
      errors++;
      $display("FAIL reset_ctl: we_n=%b oe=%b acks=%b%b%b owner=%0d, want 1 0 000 3",
               sram_we_n, sram_oe, vid_ack, cpu_ack, dma_ack, owner);
    end
    checks++;
    if ({sram_addr, sram_wdata, rdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want all 0",
               sram_addr, sram_wdata, rdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if (owner !== 2'd3) begin
      errors++;
      $display("FAIL reset_idle_owner: got %0d want 3", owner);
    end
  endtask

  task automatic test_read_latency();
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h12345;
    step();  // grant edge
    checks++;
    if ({owner, sram_addr, cpu_ack, sram_oe} !== {2'd1, 19'h12345, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rd_grant: owner=%0d addr=%h ack=%b oe=%b, want 1 12345 0 0",
               owner, sram_addr, cpu_ack, sram_oe);
    end
    step();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_ack: cpu_ack=%b want 0", cpu_ack);
    end
    step();  // grant + 2
    checks++;
    if ({cpu_ack, rdata, sram_addr} !== {1'b1, 8'hA5, 19'h12345}) begin
      errors++;
      $display("FAIL rd_ack: ack=%b rdata=%h addr=%h, want 1 a5 12345",
               cpu_ack, rdata, sram_addr);
    end
    cpu_req = 0;
    step();
    checks++;
    if ({cpu_ack, owner, rdata} !== {1'b0, 2'd3, 8'hA5}) begin
      errors++;
      $display("FAIL rd_after: ack=%b owner=%0d rdata=%h, want 0 3 a5", cpu_ack, owner, rdata);
    end
  endtask

  task automatic test_write_waveform();
    logic [2:0] exp_oe, exp_we_n, exp_ack;
    exp_oe = 3'b111; exp_we_n = 3'b101; exp_ack = 3'b001;  // bit 2 = first cycle
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00100; cpu_wdata = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({sram_oe, sram_we_n, cpu_ack, sram_addr, sram_wdata}
          !== {exp_oe[2-c], exp_we_n[2-c], exp_ack[2-c], 19'h00100, 8'h5A}) begin
        errors++;
        $display("FAIL wr_cycle%0d: oe=%b we_n=%b ack=%b addr=%h wdata=%h, want %b %b %b 00100 5a",
                 c, sram_oe, sram_we_n, cpu_ack, sram_addr, sram_wdata,
                 exp_oe[2-c], exp_we_n[2-c], exp_ack[2-c]);
      end
      if (c == 2) cpu_req = 0;
    end
    step();
    checks++;
    if ({sram_oe, sram_we_n, cpu_ack, owner, rdata} !== {1'b0, 1'b1, 1'b0, 2'd3, 8'hA5}) begin
      errors++;
      $display("FAIL wr_after: oe=%b we_n=%b ack=%b owner=%0d rdata=%h, want 0 1 0 3 a5",
               sram_oe, sram_we_n, cpu_ack, owner, rdata);
    end
    cpu_we = 0;
  endtask

  task automatic test_contention();
    vid_req = 1; vid_addr = 19'h00777;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00042;
    step();
    checks++;
    if ({owner, sram_addr} !== {2'd0, 19'h00777}) begin
      errors++;
      $display("FAIL cont_vid_grant: owner=%0d addr=%h want 0 00777", owner, sram_addr);
    end
    step();
    step();
    checks++;
    if ({vid_ack, cpu_ack, rdata} !== {1'b1, 1'b0, 8'h77}) begin
      errors++;
      $display("FAIL cont_vid_ack: vid_ack=%b cpu_ack=%b rdata=%h want 1 0 77",
               vid_ack, cpu_ack, rdata);
    end
    vid_req = 0;
    step();
    checks++;
    if ({owner, sram_addr, vid_ack} !== {2'd1, 19'h00042, 1'b0}) begin
      errors++;
      $display("FAIL cont_cpu_grant: owner=%0d addr=%h vid_ack=%b want 1 00042 0",
               owner, sram_addr, vid_ack);
    end
    step();
    step();
    checks++;
    if ({cpu_ack, rdata} !== {1'b1, 8'h42}) begin
      errors++;
      $display("FAIL cont_cpu_ack: cpu_ack=%b rdata=%h want 1 42", cpu_ack, rdata);
    end
    cpu_req = 0;
    step();
  endtask

  // vid keeps requesting, so cpu and dma alternate with it; cpu wins twice over a waiting
  // dma, then dma is promoted.
  task automatic test_starvation();
    logic [1:0] exp_own [12];
    logic [2:0] ack_got, ack_want;
    exp_own = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2};
    vid_req = 1; vid_addr = 19'h00003;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00001;
    dma_req = 1; dma_we = 0; dma_addr = 19'h00002;
    for (int g = 0; g < 12; g++) begin
      step();
      checks++;
      if (owner !== exp_own[g]) begin
        errors++;
        $display("FAIL starve_grant%0d: owner=%0d want %0d", g, owner, exp_own[g]);
      end
      step();
      step();
      ack_got  = {dma_ack, cpu_ack, vid_ack};
      ack_want = 3'b001 << exp_own[g];
      checks++;
      if (ack_got !== ack_want) begin
        errors++;
        $display("FAIL starve_ack%0d: acks=%b want %b", g, ack_got, ack_want);
      end
      if (g == 11) begin
        vid_req = 0; cpu_req = 0; dma_req = 0;
      end
    end
    step();
    checks++;
    if (owner !== 2'd3) begin
      errors++;
      $display("FAIL starve_idle: owner=%0d want 3", owner);
    end
  endtask

  task automatic test_reset_mid_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00200; cpu_wdata = 8'h11;
    step();
    step();
    checks++;
    if ({sram_we_n, sram_oe} !== 2'b01) begin
      errors++;
      $display("FAIL rstw_pulse: we_n=%b oe=%b want 0 1", sram_we_n, sram_oe);
    end
    rst = 1;
    step();
    checks++;
    if ({sram_we_n, sram_oe, owner, vid_ack, cpu_ack, dma_ack} !== 7'b1_0_11_000) begin
      errors++;
      $display("FAIL rstw_after: we_n=%b oe=%b owner=%0d acks=%b%b%b want 1 0 3 000",
               sram_we_n, sram_oe, owner, vid_ack, cpu_ack, dma_ack);
    end
    rst = 0; cpu_req = 0; cpu_we = 0;
    step();
    checks++;
    if ({cpu_ack, owner, sram_we_n} !== {1'b0, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL rstw_noack: cpu_ack=%b owner=%0d we_n=%b want 0 3 1",
               cpu_ack, owner, sram_we_n);
    end
  endtask

  // A lone vid requester is masked on its own ack edge, so it is served every RD_CYCLES+2.
  task automatic test_back_to_back();
    int last_ack = -1;
    int n_acks = 0;
    vid_req = 1; vid_addr = 19'h00055;
    for (int c = 1; c <= 24; c++) begin
      step();
      checks++;
      if ({sram_we_n, sram_oe, cpu_ack, dma_ack} !== 4'b1000) begin
        errors++;
        $display("FAIL b2b_bus_c%0d: we_n=%b oe=%b cpu_ack=%b dma_ack=%b want 1 0 0 0",
                 c, sram_we_n, sram_oe, cpu_ack, dma_ack);
      end
      if (vid_ack === 1'b1) begin
        if (last_ack >= 0) begin
          checks++;
          if (c - last_ack !== 4) begin
            errors++;
            $display("FAIL b2b_interval: got %0d clocks want 4", c - last_ack);
          end
        end
        last_ack = c;
        n_acks++;
      end
    end
    checks++;
    if (n_acks !== 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d acks want 6", n_acks);
    end
    checks++;
    if (rdata !== 8'h55) begin
      errors++;
      $display("FAIL b2b_rdata: got %h want 55", rdata);
    end
    vid_req = 0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_waveform();
    test_contention();
    test_starvation();
    test_reset_mid_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
